// File: rtl/sm_pkg.sv
// Shared definitions for the stack-machine program sequencer.
// Holds opcode constants, the error-code encoding and the sequencer FSM states.
package sm_pkg;

  localparam logic [2:0] OP_PUSH = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_MUL  = 3'b011;

  localparam int               ERR_W  = 3;
  localparam logic [ERR_W-1:0] ERR_OK = '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

endpackage

// File: rtl/sm_res_track.sv
// Result tracker: tags each core result with the pc it was issued at,
// registers it, and keeps ok/error tallies plus the pc of the first error.
module sm_res_track
  import sm_pkg::*;
#(
  parameter int AW = 10,
  parameter int DW = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [AW-1:0]    issue_pc,
  input  logic             accept,
  input  logic [DW-1:0]    data,
  input  logic [ERR_W-1:0] err,
  output logic             res_valid,
  output logic [AW-1:0]    res_pc,
  output logic [DW-1:0]    res_data,
  output logic [ERR_W-1:0] res_err,
  output logic [AW:0]      ok_cnt,
  output logic [AW:0]      err_cnt,
  output logic [AW-1:0]    first_err_pc
);

  logic [AW-1:0] tag_pc;
  logic          err_seen;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_pc       <= '0;
      res_valid    <= 1'b0;
      res_pc       <= '0;
      res_data     <= '0;
      res_err      <= '0;
      ok_cnt       <= '0;
      err_cnt      <= '0;
      first_err_pc <= '0;
      err_seen     <= 1'b0;
    end else begin
      // A result always belongs to the instruction issued one cycle earlier.
      tag_pc    <= issue_pc;
      res_valid <= accept;
      if (accept) begin
        res_pc   <= tag_pc;
        res_data <= data;
        res_err  <= err;
      end
      if (clr) begin
        ok_cnt       <= '0;
        err_cnt      <= '0;
        first_err_pc <= '0;
        err_seen     <= 1'b0;
      end else if (accept) begin
        if (err == ERR_OK) begin
          ok_cnt <= ok_cnt + 1'b1;
        end else begin
          err_cnt <= err_cnt + 1'b1;
          if (!err_seen) begin
            err_seen     <= 1'b1;
            first_err_pc <= tag_pc;
          end
        end
      end
    end
  end

endmodule

// File: rtl/sm_seq.sv
// Program sequencer: fetches instructions from a synchronous ROM, issues one
// per cycle to the core, and optionally aborts the run on the first core error.
module sm_seq
  import sm_pkg::*;
#(
  parameter int AW = 10,
  parameter int IW = 13,
  parameter int DW = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [AW:0]      prog_len,
  input  logic             halt_on_err,
  output logic             rom_en,
  output logic [AW-1:0]    rom_addr,
  input  logic [IW-1:0]    rom_data,
  output logic             core_clr,
  output logic             core_valid,
  output logic [IW-1:0]    core_instr,
  input  logic             core_d_valid,
  input  logic [DW-1:0]    core_out_data,
  input  logic [ERR_W-1:0] core_err,
  output logic             busy,
  output logic             done,
  output logic             res_valid,
  output logic [AW-1:0]    res_pc,
  output logic [DW-1:0]    res_data,
  output logic [ERR_W-1:0] res_err,
  output logic [AW:0]      ok_cnt,
  output logic [AW:0]      err_cnt,
  output logic [AW-1:0]    first_err_pc
);

  state_t      state_q, state_d;
  logic [AW:0] prog_len_q;
  logic [AW:0] fetch_addr;
  logic [AW:0] issue_pc;
  logic        halt_q;
  logic        start_ok;
  logic        abort;
  logic        accept;

  assign start_ok = (state_q == S_IDLE) && start;
  assign abort    = (state_q == S_RUN) && halt_q && core_d_valid && (core_err != ERR_OK);
  assign accept   = core_d_valid && ((state_q == S_RUN) || (state_q == S_DRAIN));

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    rom_en     = 1'b0;
    core_clr   = 1'b0;
    core_valid = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = (prog_len == '0) ? S_DONE : S_FETCH;
      end
      S_FETCH: begin
        core_clr = 1'b1;
        rom_en   = 1'b1;
        state_d  = S_RUN;
      end
      S_RUN: begin
        // An error result squashes the instruction on the bus this cycle.
        if (abort) begin
          state_d = S_DONE;
        end else begin
          core_valid = 1'b1;
          rom_en     = (fetch_addr < prog_len_q);
          if (issue_pc == prog_len_q - 1'b1) state_d = S_DRAIN;
        end
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign rom_addr   = rom_en ? fetch_addr[AW-1:0] : '0;
  assign core_instr = core_valid ? rom_data : '0;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      prog_len_q <= '0;
      halt_q     <= 1'b0;
      fetch_addr <= '0;
      issue_pc   <= '0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        prog_len_q <= prog_len;
        halt_q     <= halt_on_err;
        fetch_addr <= '0;
        issue_pc   <= '0;
      end else begin
        if (rom_en)     fetch_addr <= fetch_addr + 1'b1;
        if (core_valid) issue_pc   <= issue_pc + 1'b1;
      end
    end
  end

  sm_res_track #(
    .AW(AW),
    .DW(DW)
  ) u_res_track (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (start_ok),
    .issue_pc     (issue_pc[AW-1:0]),
    .accept       (accept),
    .data         (core_out_data),
    .err          (core_err),
    .res_valid    (res_valid),
    .res_pc       (res_pc),
    .res_data     (res_data),
    .res_err      (res_err),
    .ok_cnt       (ok_cnt),
    .err_cnt      (err_cnt),
    .first_err_pc (first_err_pc)
  );

endmodule

// File: tb/tb_sm_seq.sv
// Directed bench for sm_seq with a synchronous ROM model and a core model
// that returns per-pc results one cycle after issue.
module tb_sm_seq;
  import sm_pkg::*;

  localparam int AW = 10;
  localparam int IW = 13;
  localparam int DW = 20;
  localparam int NCAP = 1100;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [AW:0]      prog_len = '0;
  logic             halt_on_err = 1'b0;
  logic             rom_en;
  logic [AW-1:0]    rom_addr;
  logic [IW-1:0]    rom_data = '0;
  logic             core_clr;
  logic             core_valid;
  logic [IW-1:0]    core_instr;
  logic             core_d_valid = 1'b0;
  logic [DW-1:0]    core_out_data = '0;
  logic [ERR_W-1:0] core_err = '0;
  logic             busy, done, res_valid;
  logic [AW-1:0]    res_pc;
  logic [DW-1:0]    res_data;
  logic [ERR_W-1:0] res_err;
  logic [AW:0]      ok_cnt, err_cnt;
  logic [AW-1:0]    first_err_pc;

  int checks = 0;
  int failures = 0;

  sm_seq #(.AW(AW), .IW(IW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .prog_len(prog_len),
    .halt_on_err(halt_on_err), .rom_en(rom_en), .rom_addr(rom_addr),
    .rom_data(rom_data), .core_clr(core_clr), .core_valid(core_valid),
    .core_instr(core_instr), .core_d_valid(core_d_valid),
    .core_out_data(core_out_data), .core_err(core_err), .busy(busy),
    .done(done), .res_valid(res_valid), .res_pc(res_pc), .res_data(res_data),
    .res_err(res_err), .ok_cnt(ok_cnt), .err_cnt(err_cnt),
    .first_err_pc(first_err_pc)
  );

  always #5 clk = ~clk;

  // ROM and core models; the core sees the pc of the word fetched last cycle.
  logic [IW-1:0]    rom [0:1023];
  logic             mv  [0:1023];
  logic [DW-1:0]    md  [0:1023];
  logic [ERR_W-1:0] me  [0:1023];
  logic [AW-1:0]    rom_addr_q = '0;
  int               bad_instr = 0;

  always @(posedge clk) begin
    if (rom_en) begin
      rom_data   <= rom[rom_addr];
      rom_addr_q <= rom_addr;
    end
    core_d_valid  <= core_valid & mv[rom_addr_q];
    core_out_data <= md[rom_addr_q];
    core_err      <= me[rom_addr_q];
    if (core_valid && core_instr !== rom[rom_addr_q]) bad_instr <= bad_instr + 1;
  end

  // Per-cycle capture; index i is sampled just after edge E(i).
  logic          ob_valid [0:NCAP-1];
  logic          ob_done  [0:NCAP-1];
  logic          ob_romen [0:NCAP-1];
  logic [AW-1:0] ob_raddr [0:NCAP-1];
  logic [AW:0]   ob_ok    [0:NCAP-1];
  logic [AW:0]   ob_err   [0:NCAP-1];
  logic [AW-1:0] ob_fep   [0:NCAP-1];
  logic [AW-1:0] ob_rpc   [0:NCAP-1];
  logic [DW-1:0] ob_rdata [0:NCAP-1];
  logic [2:0]    ob_rerr  [0:NCAP-1];
  logic [IW-1:0] ob_instr [0:NCAP-1];
  logic [15:0]   vv, vd, vr, ve, vc, vb;

  task automatic sample(input int i);
    ob_valid[i] = core_valid;  ob_done[i]  = done;     ob_romen[i] = rom_en;
    ob_raddr[i] = rom_addr;    ob_ok[i]    = ok_cnt;   ob_err[i]   = err_cnt;
    ob_fep[i]   = first_err_pc; ob_rpc[i]  = res_pc;   ob_rdata[i] = res_data;
    ob_rerr[i]  = res_err;     ob_instr[i] = core_instr;
    if (i < 16) begin
      vv[i] = core_valid; vd[i] = done; vr[i] = res_valid;
      ve[i] = rom_en;     vc[i] = core_clr; vb[i] = busy;
    end
  endtask

  task automatic run(input int len, input bit halt, input int ncyc, input int pulse_idx);
    vv = '0; vd = '0; vr = '0; ve = '0; vc = '0; vb = '0;
    @(negedge clk);
    prog_len = (AW+1)'(len); halt_on_err = halt; start = 1'b1;
    @(posedge clk); #1;
    sample(0);
    start = 1'b0;
    for (int i = 1; i < ncyc; i++) begin
      @(posedge clk); #1;
      sample(i);
      start = (i == pulse_idx);
      if (i == pulse_idx) prog_len = '0;
    end
    start = 1'b0;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 1024; i++) begin
      rom[i] = '0; mv[i] = 1'b0; md[i] = '0; me[i] = '0;
    end
  endtask

  task automatic load_basic();
    clear_model();
    rom[0] = {OP_PUSH, 10'd3};
    rom[1] = {OP_PUSH, 10'd4};
    rom[2] = {OP_ADD, 10'd0};
    mv[2] = 1'b1; md[2] = 20'd7;
  endtask

  task automatic load_five();
    clear_model();
    rom[0] = {OP_PUSH, 10'd5};
    rom[1] = {OP_SUB, 10'd0};
    rom[2] = {OP_MUL, 10'd0};
    rom[3] = {3'b111, 10'h155};
    rom[4] = {3'b100, 10'h2aa};
    for (int i = 0; i < 5; i++) begin
      mv[i] = 1'b1; md[i] = DW'(100 + i);
    end
    me[1] = 3'd3;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({busy, done, rom_en, core_clr, core_valid, res_valid} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=000000", {busy, done, rom_en, core_clr, core_valid, res_valid});
    end
    checks++;
    if ({ok_cnt, err_cnt, first_err_pc, res_pc, rom_addr, core_instr} !== '0) begin
      failures++;
      $display("FAIL reset_data got ok=%0d err=%0d fep=%0d rpc=%0d", ok_cnt, err_cnt, first_err_pc, res_pc);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    int b0;
    load_basic();
    b0 = bad_instr;
    run(3, 1'b0, 8, -1);
    checks++;
    if (vv !== 16'h000E) begin failures++; $display("FAIL basic_issue got=%h exp=000e", vv); end
    checks++;
    if (vc !== 16'h0001 || ve !== 16'h0007) begin
      failures++; $display("FAIL basic_fetch clr=%h rom_en=%h exp 0001/0007", vc, ve);
    end
    checks++;
    if (vr !== 16'h0020 || ob_rpc[5] !== 10'd2 || ob_rdata[5] !== 20'd7) begin
      failures++; $display("FAIL basic_result rv=%h pc=%0d data=%0d exp 0020/2/7", vr, ob_rpc[5], ob_rdata[5]);
    end
    checks++;
    if (vd !== 16'h0020 || vb !== 16'h003F) begin
      failures++; $display("FAIL basic_done done=%h busy=%h exp 0020/003f", vd, vb);
    end
    checks++;
    if (ob_ok[5] !== 11'd1 || ob_err[5] !== 11'd0) begin
      failures++; $display("FAIL basic_counts ok=%0d err=%0d exp 1/0", ob_ok[5], ob_err[5]);
    end
    checks++;
    if (ob_instr[3] !== 13'h0400 || bad_instr != b0) begin
      failures++; $display("FAIL basic_instr got=%h bad=%0d exp 0400/0", ob_instr[3], bad_instr - b0);
    end
  endtask

  task automatic test_abort();
    load_five();
    run(5, 1'b1, 10, -1);
    checks++;
    if (vv !== 16'h0006) begin failures++; $display("FAIL abort_issue got=%h exp=0006", vv); end
    checks++;
    if (vd !== 16'h0010 || ve !== 16'h0007) begin
      failures++; $display("FAIL abort_done done=%h rom_en=%h exp 0010/0007", vd, ve);
    end
    checks++;
    if (ob_err[4] !== 11'd1 || ob_ok[4] !== 11'd1 || ob_fep[4] !== 10'd1) begin
      failures++; $display("FAIL abort_counts ok=%0d err=%0d fep=%0d exp 1/1/1", ob_ok[4], ob_err[4], ob_fep[4]);
    end
    checks++;
    if (ob_rpc[4] !== 10'd1 || ob_rerr[4] !== 3'd3) begin
      failures++; $display("FAIL abort_res pc=%0d err=%0d exp 1/3", ob_rpc[4], ob_rerr[4]);
    end
  endtask

  task automatic test_no_abort();
    load_five();
    run(5, 1'b0, 10, -1);
    checks++;
    if (vv !== 16'h003E) begin failures++; $display("FAIL noabort_issue got=%h exp=003e", vv); end
    checks++;
    if (vd !== 16'h0080) begin failures++; $display("FAIL noabort_done got=%h exp=0080", vd); end
    checks++;
    if (ob_ok[7] !== 11'd4 || ob_err[7] !== 11'd1 || ob_fep[7] !== 10'd1) begin
      failures++; $display("FAIL noabort_counts ok=%0d err=%0d fep=%0d exp 4/1/1", ob_ok[7], ob_err[7], ob_fep[7]);
    end
  endtask

  task automatic test_empty();
    run(0, 1'b0, 6, -1);
    checks++;
    if (vd !== 16'h0001 || vb !== 16'h0001) begin
      failures++; $display("FAIL empty_done done=%h busy=%h exp 0001/0001", vd, vb);
    end
    checks++;
    if (ve !== 16'h0000 || vc !== 16'h0000 || vv !== 16'h0000) begin
      failures++; $display("FAIL empty_access rom_en=%h clr=%h valid=%h exp 0", ve, vc, vv);
    end
    checks++;
    if (ob_err[0] !== 11'd0 || ob_fep[0] !== 10'd0 || ob_ok[0] !== 11'd0) begin
      failures++; $display("FAIL empty_clear ok=%0d err=%0d fep=%0d exp 0/0/0", ob_ok[0], ob_err[0], ob_fep[0]);
    end
    // A second start arrives while the next run is busy and must not disturb it.
    load_basic();
    run(3, 1'b0, 9, 2);
    checks++;
    if (vd !== 16'h0020 || vb !== 16'h003F || ob_ok[5] !== 11'd1) begin
      failures++; $display("FAIL busy_start done=%h busy=%h ok=%0d exp 0020/003f/1", vd, vb, ob_ok[5]);
    end
  endtask

  task automatic test_full();
    int done_at, nissue, b0;
    logic [AW-1:0] max_addr;
    clear_model();
    for (int i = 0; i < 1024; i++) begin
      rom[i] = {OP_PUSH, 10'(i)}; mv[i] = 1'b1; md[i] = DW'(i);
    end
    b0 = bad_instr;
    run(1024, 1'b0, 1030, -1);
    done_at = -1; nissue = 0; max_addr = '0;
    for (int i = 0; i < 1030; i++) begin
      if (ob_done[i] && done_at < 0) done_at = i;
      if (ob_valid[i]) nissue++;
      if (ob_romen[i] && ob_raddr[i] > max_addr) max_addr = ob_raddr[i];
    end
    checks++;
    if (done_at != 1026) begin failures++; $display("FAIL full_done got=%0d exp=1026", done_at); end
    checks++;
    if (max_addr !== 10'd1023 || nissue != 1024 || bad_instr != b0) begin
      failures++; $display("FAIL full_issue max_addr=%0d issues=%0d bad=%0d exp 1023/1024/0", max_addr, nissue, bad_instr - b0);
    end
    checks++;
    if (ob_ok[1026] !== 11'd1024 || ob_err[1026] !== 11'd0 || ob_rpc[1026] !== 10'd1023) begin
      failures++; $display("FAIL full_counts ok=%0d err=%0d rpc=%0d exp 1024/0/1023", ob_ok[1026], ob_err[1026], ob_rpc[1026]);
    end
  endtask

  task automatic test_reset_mid();
    load_five();
    run(5, 1'b0, 4, -1);
    checks++;
    if (ob_ok[3] !== 11'd1 || !busy) begin
      failures++; $display("FAIL midrst_pre ok=%0d busy=%b exp 1/1", ob_ok[3], busy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, rom_en, core_clr, core_valid, res_valid} !== 6'b0 ||
        {ok_cnt, err_cnt, first_err_pc, res_pc, res_data, rom_addr, core_instr} !== '0) begin
      failures++; $display("FAIL midrst_outputs busy=%b valid=%b rom_en=%b ok=%0d exp all 0", busy, core_valid, rom_en, ok_cnt);
    end
    @(negedge clk); rst_n = 1'b1;
    load_basic();
    run(3, 1'b0, 8, -1);
    checks++;
    if (vd !== 16'h0020 || ob_ok[5] !== 11'd1 || vv !== 16'h000E) begin
      failures++; $display("FAIL midrst_rerun done=%h valid=%h ok=%0d exp 0020/000e/1", vd, vv, ob_ok[5]);
    end
  endtask

  initial begin
    clear_model();
    test_reset();
    test_basic();
    test_abort();
    test_no_abort();
    test_empty();
    test_full();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
